// File: rtl/fetch_ctrl_if.sv
// Signal bundle between fetch_ctrl and its neighbours: instruction memory, decode,
// the execute-stage redirect, and status/debug outputs.
interface fetch_ctrl_if;
    // Valid/ready: a transfer happens in a cycle where both valid and ready are high
    // at the rising edge. Request valid and request PC depend only on registered state.
    // Memory responses have no ready: they are always accepted, in request order.
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_request_pc_o;
    logic        imem_resp_valid_i;
    logic [31:0] imem_response_pc_i;
    logic [31:0] imem_response_instr_i;
    logic        decode_valid_o;
    logic        decode_ready_i;
    logic [31:0] decode_instr_o;
    logic [31:0] decode_pc_o;
    logic        br_taken_i;
    logic [31:0] br_tgt_addr_i;
    logic        pc_mismatch_o;
    logic [1:0]  dbg_state;

    modport master (
        output imem_req_valid_o, imem_request_pc_o, decode_valid_o, decode_instr_o,
               decode_pc_o, pc_mismatch_o, dbg_state,
        input  imem_req_ready_i, imem_resp_valid_i, imem_response_pc_i,
               imem_response_instr_i, decode_ready_i, br_taken_i, br_tgt_addr_i
    );

    modport slave (
        input  imem_req_valid_o, imem_request_pc_o, decode_valid_o, decode_instr_o,
               decode_pc_o, pc_mismatch_o, dbg_state,
        output imem_req_ready_i, imem_resp_valid_i, imem_response_pc_i,
               imem_response_instr_i, decode_ready_i, br_taken_i, br_tgt_addr_i
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: credit-limited sequential fetch into an in-order instruction queue,
// with branch redirect flushing the queue and dropping stale in-flight responses.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input logic          clk_i,
    input logic          rst_i,
    fetch_ctrl_if.master bus
);
    localparam int unsigned    CW      = $clog2(QDEPTH) + 1;
    localparam int unsigned    PW      = $clog2(QDEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(QDEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   exp_pc;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          mismatch_q;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];

    logic          req_valid;
    logic          req_fire;
    logic          resp_fire;
    logic          head_valid;
    logic          push;
    logic          pop;
    logic [CW-1:0] credit_used;
    logic [CW-1:0] outs_next;
    logic [CW-1:0] drop_next;
    logic [31:0]   tgt_pc;

    // Credit counts both queued and in-flight instructions, so the queue cannot overflow.
    always_comb begin
        credit_used = occupancy + outstanding;
        req_valid   = (state == RUN) && (credit_used < DEPTH_C);
        req_fire    = req_valid && bus.imem_req_ready_i;
        resp_fire   = bus.imem_resp_valid_i && (outstanding != '0);
        head_valid  = (occupancy != '0);
        pop         = head_valid && bus.decode_ready_i && !bus.br_taken_i;
        push        = resp_fire && (drop_cnt == '0) && !bus.br_taken_i;
        outs_next   = outstanding + CW'(req_fire) - CW'(resp_fire);
        drop_next   = drop_cnt - CW'(resp_fire && (drop_cnt != '0));
        tgt_pc      = bus.br_tgt_addr_i & ~32'h3;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            exp_pc      <= RESET_PC;
            occupancy   <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            mismatch_q  <= 1'b0;
        end else begin
            outstanding <= outs_next;
            mismatch_q  <= push && (bus.imem_response_pc_i != exp_pc);
            if (bus.br_taken_i) begin
                // Everything in flight at this edge, including a request accepted now, is stale.
                fetch_pc  <= tgt_pc;
                exp_pc    <= tgt_pc;
                occupancy <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                drop_cnt  <= outs_next;
                state     <= (outs_next != '0) ? FLUSH : RUN;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (push) begin
                    exp_pc <= exp_pc + 32'd4;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                occupancy <= occupancy + CW'(push) - CW'(pop);
                drop_cnt  <= drop_next;
                if (state != FLUSH || drop_next == '0) state <= RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_pc[wr_ptr]    <= bus.imem_response_pc_i;
            q_instr[wr_ptr] <= bus.imem_response_instr_i;
        end
    end

    assign bus.imem_req_valid_o  = req_valid;
    assign bus.imem_request_pc_o = fetch_pc;
    assign bus.decode_valid_o    = head_valid;
    assign bus.decode_instr_o    = head_valid ? q_instr[rd_ptr] : NOP;
    assign bus.decode_pc_o       = head_valid ? q_pc[rd_ptr] : 32'h0;
    assign bus.pc_mismatch_o     = mismatch_q;
    assign bus.dbg_state         = state;
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the instruction memory and the decode stage of the Samsun core. It generates sequential PCs and issues requests to instruction memory under a credit limit. It buffers returned instructions in a small in-order queue toward decode and handles branch redirects from execute by flushing the queue and discarding in-flight stale responses.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QDEPTH, 4, instruction queue entries (power of two, ≥2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request this cycle
- imem_request_pc_o  out  32  request address, bits [1:0] always 0
- imem_resp_valid_i  in  1  response valid; memory returns responses in request order
- imem_response_pc_i  in  32  PC of returned instruction
- imem_response_instr_i  in  32  returned instruction word
- decode_valid_o  out  1  queue head valid toward decode
- decode_ready_i  in  1  decode accepts head this cycle
- decode_instr_o  out  32  head instruction; 32'h0000_0013 when decode_valid_o=0
- decode_pc_o  out  32  head PC; 0 when decode_valid_o=0
- br_taken_i  in  1  redirect request from execute
- br_tgt_addr_i  in  32  redirect target; bits [1:0] ignored (forced 0)
- pc_mismatch_o  out  1  one-cycle pulse: accepted response PC ≠ expected PC

## Operation
- Reset values: imem_req_valid_o=0, imem_request_pc_o=RESET_PC, decode_valid_o=0, decode_instr_o=32'h13, decode_pc_o=0, pc_mismatch_o=0; queue empty; outstanding=0; drop_cnt=0; state BOOT.
- FSM:
  - BOOT: issues no requests; goes to RUN next cycle.
  - RUN: imem_req_valid_o = (occupancy + outstanding < QDEPTH), computed from registered values only, never from br_taken_i. On request handshake, fetch PC += 4 and outstanding++.
  - FLUSH: imem_req_valid_o=0. Goes to RUN in the cycle after drop_cnt reaches 0.
- Response handling:
  - drop_cnt>0: response is discarded, drop_cnt--, outstanding--.
  - Otherwise: written to the queue tail, outstanding--, expected PC += 4.
  - pc_mismatch_o pulses when imem_response_pc_i ≠ expected PC. The instruction is still enqueued.
- Decode: head is popped on decode_valid_o && decode_ready_i. Push and pop in the same cycle leave occupancy unchanged.
- Redirect (br_taken_i=1), highest priority, applied at the clock edge:
  - Queue is cleared, regardless of any decode handshake in the same cycle.
  - Fetch PC and expected PC are set to {br_tgt_addr_i[31:2],2'b00}.
  - drop_cnt = outstanding, plus 1 if a request is accepted this cycle, minus 1 if a response arrives this cycle. A response arriving in the redirect cycle is always discarded.
  - Next state is FLUSH if the new drop_cnt>0, else RUN.
- A redirect during FLUSH updates the PC. drop_cnt is unchanged because no requests issue in FLUSH.
- A redirect during BOOT updates the PC; the FSM still goes to RUN.
- Overflow is impossible by the credit rule. A response with outstanding=0 is a protocol error: it is ignored, with no state change.
- Counters (occupancy, outstanding, drop_cnt) are $clog2(QDEPTH)+1 bits wide. PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset released at edge E: BOOT in cycle E, first request (PC=RESET_PC) in cycle E+1.
- A response accepted in cycle N gives decode_valid_o=1 in cycle N+1. There is no combinational path from imem to decode.
- A redirect at edge R gives decode_valid_o=0 in cycle R+1.
- First request to the target:
  - In cycle R+1 if no stale responses are outstanding.
  - Otherwise, in the cycle after the last stale response is dropped.
- Sustained throughput is one instruction per cycle when memory latency + 1 ≤ QDEPTH.
- Reset asserted mid-operation clears all state immediately (asynchronous). In-flight responses after reset release are protocol-illegal.

## Test plan
- Reset release, memory always ready with 1-cycle latency, decode always ready → requests 0x0,0x4,0x8,… on consecutive cycles; decode sees PC 0x0 two cycles after first request, then one instruction per cycle.
- decode_ready_i=0 for 10 cycles → exactly 4 requests issued, imem_req_valid_o=0 afterwards; on ready=1, decode receives PCs 0x0..0xC in order, then fetch resumes at 0x10.
- br_taken_i=1, target 0x0000_1002, with 2 requests outstanding → decode_valid_o=0 next cycle, 2 responses dropped, FLUSH then first request at 0x1000, first decoded PC 0x1000.
- Redirect in the same cycle as a response, a request accept and a decode pop → queue empty, the response dropped, the accepted request counted in drop_cnt, no stale PC ever reaches decode.
- Response PC 0x20 when expected 0x1C → pc_mismatch_o=1 for exactly one cycle; instruction still delivered with decode_pc_o=0x20.
- Start at RESET_PC=32'hFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; rst_i low mid-stream → all outputs at reset values in the same cycle.
